// File: rtl/serial_adder_if.sv
// rtl/serial_adder_if.sv - operand/result handshake bundle for serial_adder
interface serial_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, sum, cout, overflow
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum, cout, overflow
    );
endinterface

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial add/sub, LSB first; SERIAL_ADDER_OVF_EN enables signed overflow
module serial_adder #(
    parameter int WIDTH = 32
) (
    input logic          clk,
    input logic          reset,
    serial_adder_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_q;
    logic             carry;
    logic             cout_q;
    logic [CW-1:0]    cnt;
    logic             s_bit;
    logic             c_next;
    logic             last_bit;

    // One full-adder cell; A's vacated MSB doubles as the result shift register
    assign s_bit    = a_sr[0] ^ b_sr[0] ^ carry;
    assign c_next   = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
    assign last_bit = (cnt == CW'(WIDTH - 1));

    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake outputs decoded from the state register
    always_comb begin
        state_d       = state_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (last_bit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand load, bit-serial datapath and result capture on the final bit
    always_ff @(posedge clk) begin
        if (reset) begin
            a_sr   <= '0;
            b_sr   <= '0;
            sum_q  <= '0;
            carry  <= 1'b0;
            cout_q <= 1'b0;
            cnt    <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_sr  <= bus.a;
                        b_sr  <= bus.b ^ {WIDTH{bus.sub}};
                        carry <= bus.sub;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_sr  <= {s_bit, a_sr[WIDTH-1:1]};
                    b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
                    carry <= c_next;
                    cnt   <= cnt + CW'(1);
                    if (last_bit) begin
                        sum_q  <= {s_bit, a_sr[WIDTH-1:1]};
                        cout_q <= c_next;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic c_msb_in;
    logic ovf_q;

    // Carry entering the MSB cell is the live carry during the last RUN cycle
    assign c_msb_in     = carry;
    assign bus.overflow = ovf_q;

    // Signed overflow: carry into MSB differs from carry out of MSB
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else if (state_q == RUN && last_bit) begin
            ovf_q <= c_msb_in ^ c_next;
        end
    end
`else
    assign bus.overflow = 1'b0;
`endif
endmodule
